// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, carry/zero/overflow flags and an out_valid pulse.
// Define ALU_SEQ_MUL_EN to make op 111 an iterative N-cycle shift-add multiply; otherwise op 111 is XOR.
module alu_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic         c_out,
  output logic         zero,
  output logic         ovf
);

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_NOT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_X   = 3'b111;

  logic [N-1:0] result_q;
  logic         c_out_q, zero_q, ovf_q, out_valid_q;

  logic [N:0]   sum_add, sum_sub;
  logic [N-1:0] alu_res_d;
  logic         alu_c_d, alu_ovf_d;

  assign sum_add = {1'b0, a} + {1'b0, b}  + {{N{1'b0}}, c_in};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, c_in};

  // Single-cycle datapath; op 111 yields XOR here and is only used when MUL is not built.
  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_ovf_d = 1'b0;
    case (op)
      OP_MOV: alu_res_d = a;
      OP_NOT: alu_res_d = ~a;
      OP_ADD: begin
        alu_res_d = sum_add[N-1:0];
        alu_c_d   = sum_add[N];
        alu_ovf_d = (a[N-1] == b[N-1]) && (sum_add[N-1] != a[N-1]);
      end
      OP_SUB: begin
        alu_res_d = sum_sub[N-1:0];
        alu_c_d   = sum_sub[N];
        alu_ovf_d = (a[N-1] != b[N-1]) && (sum_sub[N-1] != a[N-1]);
      end
      OP_OR:  alu_res_d = a | b;
      OP_AND: alu_res_d = a & b;
      OP_SLT: alu_res_d = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_X:   alu_res_d = a ^ b;
      default: alu_res_d = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(N);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*N-1:0]  acc_q, mcand_q;
  logic [N-1:0]    mplier_q;
  logic [2*N-1:0]  acc_d;

  assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*N){1'b0}});
  assign in_ready = (state_q == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      result_q    <= '0;
      c_out_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (op == OP_X) begin
              state_q  <= S_MUL;
              cnt_q    <= CW'(N-1);
              acc_q    <= '0;
              mcand_q  <= {{N{1'b0}}, a};
              mplier_q <= b;
            end else begin
              result_q    <= alu_res_d;
              c_out_q     <= alu_c_d;
              ovf_q       <= alu_ovf_d;
              zero_q      <= (alu_res_d == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
          // Last of N iterations: publish straight from the adder output.
          if (cnt_q == '0) begin
            state_q     <= S_IDLE;
            result_q    <= acc_d[N-1:0];
            c_out_q     <= |acc_d[2*N-1:N];
            ovf_q       <= 1'b0;
            zero_q      <= (acc_d[N-1:0] == '0);
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  assign in_ready = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      c_out_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q <= alu_res_d;
        c_out_q  <= alu_c_d;
        ovf_q    <= alu_ovf_d;
        zero_q   <= (alu_res_d == '0);
      end
    end
  end
`endif

  assign result    = result_q;
  assign c_out     = c_out_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (N=32); covers MUL or XOR depending on ALU_SEQ_MUL_EN.
module tb_alu_seq;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] a, b;
  logic         c_in;
  logic         out_valid;
  logic [N-1:0] result;
  logic         c_out, zero, ovf;

  int n_assert = 0;
  int n_fail   = 0;

  alu_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .result(result), .c_out(c_out), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge, then drop in_valid; outputs sampled 1ns after the edge.
  task automatic issue(input logic [2:0] o, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic ci);
    op = o; a = av; b = bv; c_in = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] r, input logic c,
                         input logic z, input logic v);
    chk({tag, ".vld"},  {63'd0, out_valid}, 64'd1);
    chk({tag, ".res"},  {32'd0, result},    {32'd0, r});
    chk({tag, ".cout"}, {63'd0, c_out},     {63'd0, c});
    chk({tag, ".zero"}, {63'd0, zero},      {63'd0, z});
    chk({tag, ".ovf"},  {63'd0, ovf},       {63'd0, v});
  endtask

  initial begin
    int seen_vld;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; c_in = 1'b0;
    #23;
    chk("rst.res",   {32'd0, result}, 64'd0);
    chk("rst.vld",   {63'd0, out_valid}, 64'd0);
    chk("rst.rdy",   {63'd0, in_ready}, 64'd1);
    chk("rst.flags", {61'd0, c_out, zero, ovf}, 64'd0);
    rst = 1'b0;
    tick();

    issue(3'b010, 32'hFFFF_FFFF, 32'h1, 1'b0);
    chk_out("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("hold.vld", {63'd0, out_valid}, 64'd0);
    chk("hold.res", {32'd0, result}, 64'd0);

    issue(3'b011, 32'd5, 32'd3, 1'b1);
    chk_out("sub_5_3", 32'd2, 1'b1, 1'b0, 1'b0);
    issue(3'b011, 32'd3, 32'd5, 1'b1);
    chk_out("sub_3_5", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    issue(3'b010, 32'h7FFF_FFFF, 32'h1, 1'b0);
    chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    issue(3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0);
    chk_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
    issue(3'b110, 32'h1, 32'hFFFF_FFFF, 1'b0);
    chk_out("slt_pos", 32'd0, 1'b0, 1'b1, 1'b0);

    // back-to-back issue: in_valid stays high across the four edges
    issue(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    chk_out("b2b_mov", 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    chk_out("b2b_not", 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
    issue(3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    chk_out("b2b_or",  32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    issue(3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    chk_out("b2b_and", 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    chk("b2b.rdy", {63'd0, in_ready}, 64'd1);

`ifdef ALU_SEQ_MUL_EN
    issue(3'b111, 32'h0001_0000, 32'h0001_0003, 1'b0);
    // keep a MOV pending the whole time; it must not be taken while busy
    op = 3'b000; a = 32'hDEAD_BEEF; in_valid = 1'b1;
    chk("mul.rdy0", {63'd0, in_ready}, 64'd0);
    chk("mul.vld0", {63'd0, out_valid}, 64'd0);
    seen_vld = 0;
    for (int k = 1; k < N; k++) begin
      tick();
      if (out_valid || in_ready) seen_vld++;
    end
    chk("mul.early", seen_vld, 64'd0);
    tick();
    chk_out("mul", 32'h0003_0000, 1'b1, 1'b0, 1'b0);
    chk("mul.rdy1", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk_out("mul_then_mov", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);

    // abort an in-flight MUL with reset
    issue(3'b111, 32'h0001_0000, 32'h0001_0003, 1'b0);
    repeat (4) tick();
    chk("abort.busy", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    #1;
    chk("abort.res", {32'd0, result}, 64'd0);
    chk("abort.rdy", {63'd0, in_ready}, 64'd1);
    chk("abort.outs", {60'd0, out_valid, c_out, zero, ovf}, 64'd0);
    #2;
    rst = 1'b0;
    seen_vld = 0;
    for (int k = 0; k < N + 4; k++) begin
      tick();
      if (out_valid) seen_vld++;
    end
    chk("abort.novld", seen_vld, 64'd0);
`else
    issue(3'b111, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0);
    chk_out("xor", 32'hF00F_F00F, 1'b0, 1'b0, 1'b0);
    chk("xor.rdy", {63'd0, in_ready}, 64'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("rst2.res", {32'd0, result}, 64'd0);
    chk("rst2.outs", {60'd0, out_valid, c_out, zero, ovf}, 64'd0);
    chk("rst2.rdy", {63'd0, in_ready}, 64'd1);
    #2;
    rst = 1'b0;
    seen_vld = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid) seen_vld++;
    end
    chk("rst2.novld", seen_vld, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
